// File: rtl/sigma_gpio_csr_pkg.sv
// Shared register offsets, bank stride and byte-enable helper for the sigma GPIO/CSR block.
package sigma_gpio_pkg;

  localparam logic [4:0] GPIO_OFS_OUT     = 5'h00;
  localparam logic [4:0] GPIO_OFS_IN      = 5'h04;
  localparam logic [4:0] GPIO_OFS_SET     = 5'h08;
  localparam logic [4:0] GPIO_OFS_CLR     = 5'h0C;
  localparam logic [4:0] GPIO_OFS_EN_RISE = 5'h10;
  localparam logic [4:0] GPIO_OFS_EN_FALL = 5'h14;
  localparam logic [4:0] GPIO_OFS_STATUS  = 5'h18;
  localparam logic [4:0] GPIO_OFS_TGL     = 5'h1C;

  localparam logic [31:0] GPIO_BANK_STRIDE = 32'h20;

  function automatic logic [31:0] gpio_be_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/sigma_gpio_csr_if.sv
// Split request/response xif bus between the tile and the GPIO/CSR block.
// Handshake: a transfer happens on any cycle with req && ack; writes get no
// response, every read gets exactly one resp pulse (with rdata) the next cycle.
interface sigma_gpio_csr_if;
  logic        bus_req_i;
  logic        bus_we_i;
  logic [31:0] bus_addr_bi;
  logic [3:0]  bus_be_bi;
  logic [31:0] bus_wdata_bi;
  logic        bus_ack_o;
  logic        bus_resp_o;
  logic [31:0] bus_rdata_bo;

  modport master (
    output bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    input  bus_ack_o, bus_resp_o, bus_rdata_bo
  );

  modport slave (
    input  bus_req_i, bus_we_i, bus_addr_bi, bus_be_bi, bus_wdata_bi,
    output bus_ack_o, bus_resp_o, bus_rdata_bo
  );
endinterface

// File: rtl/sigma_gpio_csr_bank.sv
// One GPIO bank: OUT/enable/status registers, input synchroniser and edge detect.
// Offset 0x1C becomes OUT_TGL when SIGMA_GPIO_TOGGLE_EN is defined.
module sigma_gpio_bank
  import sigma_gpio_pkg::*;
#(
  parameter int          GPIO_WIDTH  = 32,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic                  clk_i,
  input  logic                  arst_n_i,
  input  logic                  armed_i,
  input  logic                  wr_i,
  input  logic [4:0]            ofs_i,
  input  logic [GPIO_WIDTH-1:0] wdata_i,
  input  logic [GPIO_WIDTH-1:0] wmask_i,
  input  logic [GPIO_WIDTH-1:0] gpio_i,
  output logic [GPIO_WIDTH-1:0] gpio_o,
  output logic [31:0]           rdata_o,
  output logic                  irq_o
);

  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] en_rise_q, en_rise_d;
  logic [GPIO_WIDTH-1:0] en_fall_q, en_fall_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [SYNC_STAGES-1:0][GPIO_WIDTH-1:0] sync_q;

  logic [GPIO_WIDTH-1:0] sync_last, rise, fall, evt, wbits, rd_w;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign rise      = sync_last & ~prev_q;
  assign fall      = ~sync_last & prev_q;
  // Edges seen before the arm counter expires are artefacts of the synchroniser filling.
  assign evt       = armed_i ? ((rise & en_rise_q) | (fall & en_fall_q)) : '0;
  assign wbits     = wdata_i & wmask_i;

  always_comb begin
    out_d     = out_q;
    en_rise_d = en_rise_q;
    en_fall_d = en_fall_q;
    status_d  = status_q;
    if (wr_i) begin
      case (ofs_i)
        GPIO_OFS_OUT:     out_d     = (out_q & ~wmask_i) | wbits;
        GPIO_OFS_SET:     out_d     = out_q | wbits;
        GPIO_OFS_CLR:     out_d     = out_q & ~wbits;
        GPIO_OFS_EN_RISE: en_rise_d = (en_rise_q & ~wmask_i) | wbits;
        GPIO_OFS_EN_FALL: en_fall_d = (en_fall_q & ~wmask_i) | wbits;
        GPIO_OFS_STATUS:  status_d  = status_q & ~wbits;
`ifdef SIGMA_GPIO_TOGGLE_EN
        GPIO_OFS_TGL:     out_d     = out_q ^ wbits;
`endif
        default: ;
      endcase
    end
    // A new event beats a same-cycle W1C on the same bit.
    status_d = status_d | evt;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      out_q     <= OUT_RESET[GPIO_WIDTH-1:0];
      en_rise_q <= '0;
      en_fall_q <= '0;
      status_q  <= '0;
      prev_q    <= '0;
      sync_q    <= '0;
    end else begin
      out_q     <= out_d;
      en_rise_q <= en_rise_d;
      en_fall_q <= en_fall_d;
      status_q  <= status_d;
      prev_q    <= sync_last;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    rd_w = '0;
    case (ofs_i)
      GPIO_OFS_OUT:     rd_w = out_q;
      GPIO_OFS_IN:      rd_w = sync_last;
      GPIO_OFS_EN_RISE: rd_w = en_rise_q;
      GPIO_OFS_EN_FALL: rd_w = en_fall_q;
      GPIO_OFS_STATUS:  rd_w = status_q;
      default:          rd_w = '0;
    endcase
  end

  always_comb begin
    rdata_o = '0;
    rdata_o[GPIO_WIDTH-1:0] = rd_w;
  end

  assign gpio_o = out_q;
  assign irq_o  = |status_q;

endmodule

// File: rtl/sigma_gpio_csr.sv
// GPIO/CSR peripheral top: address decode, arm counter, read response and irq.
// Optional OUT_TGL register at offset 0x1C under SIGMA_GPIO_TOGGLE_EN.
module sigma_gpio_csr
  import sigma_gpio_pkg::*;
#(
  parameter int          NUM_BANKS   = 1,
  parameter int          GPIO_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] OUT_RESET   = 32'h0
) (
  input  logic                            clk_i,
  input  logic                            arst_n_i,
  sigma_gpio_csr_if.slave                 bus,
  input  logic [NUM_BANKS*GPIO_WIDTH-1:0] gpio_bi,
  output logic [NUM_BANKS*GPIO_WIDTH-1:0] gpio_bo,
  output logic                            irq_o
);

  localparam logic [31:0] SPAN       = 32'(NUM_BANKS) * GPIO_BANK_STRIDE;
  localparam logic [2:0]  ARM_CYCLES = 3'(SYNC_STAGES + 1);

  logic        xfer, hit, wr_hit;
  logic [31:0] addr_off, be_mask, rd_mux;
  logic [2:0]  bank_sel;
  logic [4:0]  ofs;
  logic [2:0]  arm_cnt_q, arm_cnt_d;
  logic        armed;
  logic        resp_q, resp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irq_q;
  logic [NUM_BANKS-1:0]       bank_irq;
  logic [NUM_BANKS-1:0][31:0] bank_rdata;
  logic        unused_bits;

  assign bus.bus_ack_o = bus.bus_req_i;
  assign xfer     = bus.bus_req_i & bus.bus_ack_o;

  assign addr_off = bus.bus_addr_bi - BASE_ADDR;
  assign hit      = (bus.bus_addr_bi >= BASE_ADDR) && (addr_off < SPAN);
  assign bank_sel = addr_off[7:5];
  assign ofs      = {bus.bus_addr_bi[4:2], 2'b00};
  assign wr_hit   = xfer & bus.bus_we_i & hit;
  assign be_mask  = gpio_be_mask(bus.bus_be_bi);

  assign unused_bits = ^{addr_off[31:8], bus.bus_addr_bi[1:0], bus.bus_wdata_bi, be_mask};

  // Saturates at ARM_CYCLES; edge detection is held off until then.
  assign armed     = (arm_cnt_q == ARM_CYCLES);
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 3'd1;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    sigma_gpio_bank #(
      .GPIO_WIDTH (GPIO_WIDTH),
      .SYNC_STAGES(SYNC_STAGES),
      .OUT_RESET  (OUT_RESET)
    ) u_bank (
      .clk_i   (clk_i),
      .arst_n_i(arst_n_i),
      .armed_i (armed),
      .wr_i    (wr_hit && (bank_sel == 3'(b))),
      .ofs_i   (ofs),
      .wdata_i (bus.bus_wdata_bi[GPIO_WIDTH-1:0]),
      .wmask_i (be_mask[GPIO_WIDTH-1:0]),
      .gpio_i  (gpio_bi[b*GPIO_WIDTH +: GPIO_WIDTH]),
      .gpio_o  (gpio_bo[b*GPIO_WIDTH +: GPIO_WIDTH]),
      .rdata_o (bank_rdata[b]),
      .irq_o   (bank_irq[b])
    );
  end

  always_comb begin
    rd_mux = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (hit && (bank_sel == 3'(b))) rd_mux = bank_rdata[b];
    end
  end

  assign resp_d  = xfer & ~bus.bus_we_i;
  assign rdata_d = resp_d ? rd_mux : '0;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      arm_cnt_q <= '0;
      resp_q    <= 1'b0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      arm_cnt_q <= arm_cnt_d;
      resp_q    <= resp_d;
      rdata_q   <= rdata_d;
      irq_q     <= |bank_irq;
    end
  end

  assign bus.bus_resp_o   = resp_q;
  assign bus.bus_rdata_bo = rdata_q;
  assign irq_o            = irq_q;

endmodule

// File: tb/tb_sigma_gpio_csr.sv
// Directed bench for sigma_gpio_csr with two 32-bit banks at 0x8000_0000.
module tb_sigma_gpio_csr;

  localparam int NB = 2;
  localparam int W  = 32;

  logic          clk;
  logic          arst_n;
  logic [NB*W-1:0] gpio_in;
  logic [NB*W-1:0] gpio_out;
  logic          irq;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  sigma_gpio_csr_if bus_if ();

  sigma_gpio_csr #(
    .NUM_BANKS  (NB),
    .GPIO_WIDTH (W),
    .BASE_ADDR  (32'h8000_0000),
    .SYNC_STAGES(2),
    .OUT_RESET  (32'h0)
  ) dut (
    .clk_i   (clk),
    .arst_n_i(arst_n),
    .bus     (bus_if),
    .gpio_bi (gpio_in),
    .gpio_bo (gpio_out),
    .irq_o   (irq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Driver tasks: called at a negedge, return at a later negedge.
  task automatic bus_write(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] data);
    bus_if.bus_req_i    = 1'b1;
    bus_if.bus_we_i     = 1'b1;
    bus_if.bus_addr_bi  = addr;
    bus_if.bus_be_bi    = be;
    bus_if.bus_wdata_bi = data;
    #1 chk("ack", {63'd0, bus_if.bus_ack_o}, 64'd1);
    @(negedge clk);
    bus_if.bus_req_i = 1'b0;
    bus_if.bus_we_i  = 1'b0;
    chk("wr_noresp", {63'd0, bus_if.bus_resp_o}, 64'd0);
  endtask

  task automatic drive_read(input logic [31:0] addr);
    bus_if.bus_req_i   = 1'b1;
    bus_if.bus_we_i    = 1'b0;
    bus_if.bus_addr_bi = addr;
    bus_if.bus_be_bi   = 4'h0;
  endtask

  task automatic check_resp(input string tag);
    logic [31:0] e;
    chk({tag, "_resp"}, {63'd0, bus_if.bus_resp_o}, 64'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {32'd0, bus_if.bus_rdata_bo}, {32'd0, e});
    end
  endtask

  task automatic bus_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    drive_read(addr);
    exp_q.push_back(exp);
    @(negedge clk);
    bus_if.bus_req_i = 1'b0;
    check_resp(tag);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    arst_n              = 1'b0;
    gpio_in             = '1;
    bus_if.bus_req_i    = 1'b0;
    bus_if.bus_we_i     = 1'b0;
    bus_if.bus_addr_bi  = '0;
    bus_if.bus_be_bi    = '0;
    bus_if.bus_wdata_bi = '0;
    repeat (3) @(negedge clk);
    chk("rst_resp",  {63'd0, bus_if.bus_resp_o}, 64'd0);
    chk("rst_rdata", {32'd0, bus_if.bus_rdata_bo}, 64'd0);
    chk("rst_irq",   {63'd0, irq}, 64'd0);
    chk("rst_gpio",  gpio_out, 64'd0);
    arst_n = 1'b1;

    // Rise enables live while the synchroniser fills with the high pins.
    bus_write(32'h8000_0010, 4'hF, 32'hFFFF_FFFF);
    idle(10);
    bus_read("arm_status", 32'h8000_0018, 32'h0);
    chk("arm_irq",  {63'd0, irq}, 64'd0);
    chk("arm_gpio", gpio_out, 64'd0);
    chk("idle_rdata", {32'd0, bus_if.bus_rdata_bo}, 64'd0);
    bus_write(32'h8000_0010, 4'hF, 32'h0);

    // Byte-enabled write into bank 1.
    bus_write(32'h8000_0020, 4'b0011, 32'hA5A5_A5A5);
    chk("b1_gpio", gpio_out, 64'h0000_A5A5_0000_0000);
    bus_read("b1_out", 32'h8000_0020, 32'h0000_A5A5);

    // SET / CLR on bank 0.
    bus_write(32'h8000_0000, 4'hF, 32'hF0F0_F0F0);
    bus_write(32'h8000_0008, 4'hF, 32'h0000_000F);
    bus_write(32'h8000_000C, 4'hF, 32'hF000_0000);
    bus_read("setclr", 32'h8000_0000, 32'h00F0_F0FF);
    bus_write(32'h8000_0008, 4'b0001, 32'h0000_0F00);
    bus_read("set_be", 32'h8000_0000, 32'h00F0_F0FF);
    chk("setclr_gpio", gpio_out, 64'h0000_A5A5_00F0_F0FF);
    bus_read("wo_read", 32'h8000_0008, 32'h0);

    // Rise on bit 3: status after 3 cycles, irq after 4; read of same-cycle update sees old value.
    gpio_in[3] = 1'b0;
    idle(5);
    bus_write(32'h8000_0010, 4'hF, 32'h0000_0008);
    gpio_in[3] = 1'b1;
    idle(2);
    drive_read(32'h8000_0018);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h8);
    @(negedge clk);
    chk("rise_irq3", {63'd0, irq}, 64'd0);
    check_resp("rise_st3");
    @(negedge clk);
    bus_if.bus_req_i = 1'b0;
    chk("rise_irq4", {63'd0, irq}, 64'd1);
    check_resp("rise_st4");
    @(negedge clk);
    chk("b2b_end_resp",  {63'd0, bus_if.bus_resp_o}, 64'd0);
    chk("b2b_end_rdata", {32'd0, bus_if.bus_rdata_bo}, 64'd0);

    // W1C drops irq one cycle after the write cycle.
    bus_write(32'h8000_0018, 4'hF, 32'h0000_0008);
    chk("w1c_irq_hold", {63'd0, irq}, 64'd1);
    @(negedge clk);
    chk("w1c_irq_drop", {63'd0, irq}, 64'd0);

    // W1C landing on the same cycle as a new rise: set wins.
    gpio_in[3] = 1'b0;
    idle(5);
    gpio_in[3] = 1'b1;
    idle(2);
    bus_write(32'h8000_0018, 4'hF, 32'h0000_0008);
    bus_read("set_wins", 32'h8000_0018, 32'h0000_0008);
    chk("set_wins_irq", {63'd0, irq}, 64'd1);

    // Status persists after the enable is cleared; masked W1C has no effect.
    bus_write(32'h8000_0010, 4'hF, 32'h0);
    bus_read("persist", 32'h8000_0018, 32'h0000_0008);
    bus_write(32'h8000_0018, 4'b1110, 32'h0000_0008);
    bus_read("w1c_be_off", 32'h8000_0018, 32'h0000_0008);
    bus_write(32'h8000_0018, 4'b0001, 32'h0000_0008);
    bus_read("w1c_be_on", 32'h8000_0018, 32'h0);

    // Falling edge on bit 0, IN readback.
    bus_write(32'h8000_0014, 4'hF, 32'h0000_0001);
    gpio_in[0] = 1'b0;
    idle(5);
    bus_read("fall", 32'h8000_0018, 32'h0000_0001);
    bus_read("in_b0", 32'h8000_0004, 32'hFFFF_FFFE);
    bus_read("in_b1", 32'h8000_0024, 32'hFFFF_FFFF);
    bus_read("en_fall", 32'h8000_0014, 32'h0000_0001);
    bus_write(32'h8000_0018, 4'hF, 32'h0000_0001);
    idle(2);
    chk("fall_irq_clr", {63'd0, irq}, 64'd0);

    // Out-of-range accesses.
    bus_write(32'h8000_0040, 4'hF, 32'hFFFF_FFFF);
    bus_read("oob_b0", 32'h8000_0000, 32'h00F0_F0FF);
    bus_read("oob_b1", 32'h8000_0020, 32'h0000_A5A5);
    bus_read("unmap_hi", 32'h8000_1000, 32'h0);
    bus_read("unmap_lo", 32'h7FFF_FFFC, 32'h0);
    bus_read("unmap_end", 32'h8000_0040, 32'h0);

`ifdef SIGMA_GPIO_TOGGLE_EN
    bus_write(32'h8000_0000, 4'hF, 32'h0000_FFFF);
    bus_write(32'h8000_001C, 4'hF, 32'hFFFF_FFFF);
    bus_read("tgl", 32'h8000_0000, 32'hFFFF_0000);
    bus_read("tgl_rd0", 32'h8000_001C, 32'h0);
`else
    bus_read("rsvd_rd", 32'h8000_001C, 32'h0);
    bus_write(32'h8000_001C, 4'hF, 32'hFFFF_FFFF);
    bus_read("rsvd_wr", 32'h8000_0000, 32'h00F0_F0FF);
`endif

    idle(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sigma_gpio_csr.md
Name: sigma_gpio_csr

Overview:
- Parametrised GPIO/CSR peripheral for the sigma tile's external (xif) split request/response bus.
- Provides NUM_BANKS banks of GPIO_WIDTH-bit outputs and synchronised inputs.
- Supports atomic set/clear writes, byte-enable writes and per-bit rising/falling edge interrupts with W1C status.
- Drives a single level irq_o toward the tile's irq vector.

Parameters:
- NUM_BANKS, 1, number of GPIO banks (1..8).
- GPIO_WIDTH, 32, bits per bank (1..32); unused upper register bits read 0 and ignore writes.
- BASE_ADDR, 32'h80000000, bank 0 base; bank b at BASE_ADDR + b*32'h20.
- SYNC_STAGES, 2, input synchroniser depth (>=2).
- OUT_RESET, 0, reset value of every bank's OUT register (GPIO_WIDTH bits, replicated).

Ports:
- clk_i  in  1  clock
- arst_n_i  in  1  reset; asynchronous, active-low
- bus_req_i  in  1  request valid
- bus_we_i  in  1  1 = write, 0 = read
- bus_addr_bi  in  32  byte address
- bus_be_bi  in  4  byte enables (writes only)
- bus_wdata_bi  in  32  write data
- bus_ack_o  out  1  request accepted
- bus_resp_o  out  1  read response valid
- bus_rdata_bo  out  32  read data
- gpio_bi  in  NUM_BANKS*GPIO_WIDTH  raw asynchronous inputs; bank b at [b*GPIO_WIDTH +: GPIO_WIDTH]
- gpio_bo  out  NUM_BANKS*GPIO_WIDTH  registered outputs
- irq_o  out  1  registered interrupt level

Behaviour:
- Reset (async on arst_n_i low): OUT=OUT_RESET; IRQ_EN_RISE, IRQ_EN_FALL, IRQ_STATUS, all sync/prev flops, bus_resp_o, bus_rdata_bo and irq_o = 0. Arm counter = 0.
- Handshake:
  - bus_ack_o = bus_req_i (combinational; never stalls).
  - A transfer occurs when req && ack.
  - Writes produce no response.
  - Every read, mapped or not, produces exactly one bus_resp_o pulse in the next cycle. rdata is valid only with resp and is 0 otherwise.
  - Back-to-back reads give back-to-back resp pulses.
- Decode: hit when BASE_ADDR <= addr < BASE_ADDR + NUM_BANKS*32'h20. bank = (addr-BASE_ADDR)>>5, offset = addr[4:2], addr[1:0] ignored.
- Unmapped reads return 0 with resp. Unmapped writes are dropped.
- Register map (offsets):
  - 0x00 OUT: RW.
  - 0x04 IN: RO; last sync stage.
  - 0x08 OUT_SET: WO; OUT |= wdata.
  - 0x0C OUT_CLR: WO; OUT &= ~wdata.
  - 0x10 IRQ_EN_RISE: RW.
  - 0x14 IRQ_EN_FALL: RW.
  - 0x18 IRQ_STATUS: read; write-1-to-clear.
  - 0x1C: reserved; reads 0, writes ignored.
  - WO registers read 0.
- Byte enables: write bits outside enabled bytes have no effect on any register, including SET/CLR/W1C.
- gpio_bo reflects OUT one cycle after the write cycle.
- Inputs: SYNC_STAGES-flop synchroniser per bit, then a prev flop.
  - rise = sync & ~prev; fall = ~sync & prev.
  - Status bit sets when (rise & EN_RISE) | (fall & EN_FALL).
  - Pin change to status set: SYNC_STAGES+1 cycles. irq_o = |(all IRQ_STATUS), registered, so one further cycle.
- Arming: a 3-bit counter suppresses edge detection until SYNC_STAGES+1 cycles after reset release. A pin held high through reset never produces a rise event.
- Simultaneous events:
  - Status set and W1C on the same bit in the same cycle: set wins.
  - A read of IN or STATUS in the same cycle as an update returns the pre-update value.
- Enable cleared while its status bit is set: status persists until W1C.

Optional Feature:
- Macro SIGMA_GPIO_TOGGLE_EN.
- Defined: offset 0x1C is OUT_TGL, write-only, OUT ^= (wdata masked by be); reads 0.
- Undefined: 0x1C stays reserved as above.

Decomposition:
- Package sigma_gpio_pkg:
  - offset localparams GPIO_OFS_OUT, GPIO_OFS_IN, GPIO_OFS_SET, GPIO_OFS_CLR, GPIO_OFS_EN_RISE, GPIO_OFS_EN_FALL, GPIO_OFS_STATUS, GPIO_OFS_TGL;
  - GPIO_BANK_STRIDE = 32'h20;
  - a function expanding be[3:0] to a 32-bit mask.
- Sub-module sigma_gpio_bank (one per bank, generate loop) holds OUT, enables, status, synchroniser and edge logic.
- Top holds decode, arm counter, response register and irq OR.

Test Plan:
- Reset with gpio_bi all ones, then idle 10 cycles -> IRQ_STATUS reads 0; gpio_bo = OUT_RESET; irq_o = 0.
- NUM_BANKS=2: write 0xA5A5A5A5 to bank1 OUT with be=4'b0011, then read -> rdata 0x0000A5A5; bank1 gpio_bo[15:0]=0xA5A5; bank0 unchanged.
- OUT=0xF0F0F0F0, OUT_SET 0x0000000F, OUT_CLR 0xF0000000 -> OUT reads 0x00F0F0FF.
- EN_RISE[3]=1, drive gpio_bi[3] 0->1 -> STATUS bit 3 set after 3 cycles and irq_o after 4. W1C 0x8 -> irq_o drops the next cycle. W1C coincident with a new rise -> bit stays set.
- Reads of 0x80001000 and of offset 0x1C (macro undefined) -> resp one cycle later, rdata 0. Two back-to-back reads -> two consecutive resp pulses.
- SIGMA_GPIO_TOGGLE_EN defined: OUT=0x0000FFFF, write 0x1C 0xFFFFFFFF -> OUT reads 0xFFFF0000.
